// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel strobe, counters, syncs and frame markers.
// Driven by the timing generator (master) and read by pixel pipelines (slave).
interface vga_timing_gen_if;
    logic       pix_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       in_display;
    logic       line_start;
    logic       frame_start;

    modport master (
        output pix_tick, pixel_x, pixel_y, hsync, vsync,
               in_display, line_start, frame_start
    );

    modport slave (
        input  pix_tick, pixel_x, pixel_y, hsync, vsync,
               in_display, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: half-rate pixel strobe, x/y counters, registered syncs and markers.
// Flags align with counters (zero relative latency); free-running, no backpressure.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               clock_50MHz,
    input  logic               reset_n,
    vga_timing_gen_if.master   vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       r_toggle;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_in_display;
    logic       r_line_start;
    logic       r_frame_start;

    logic       w_x_wrap;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_hsync_nxt;
    logic       w_vsync_nxt;
    logic       w_disp_nxt;

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
        end
    end

    // Using >= rather than == makes any out-of-range value wrap on the next tick.
    always_comb begin
        w_x_wrap    = 1'b0;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hsync_nxt = 1'b1;
        w_vsync_nxt = 1'b1;
        w_disp_nxt  = 1'b0;

        w_x_wrap = (r_x >= X_LAST);
        w_x_nxt  = w_x_wrap ? 10'd0 : r_x + 10'd1;

        if (r_y > Y_LAST) begin
            w_y_nxt = 10'd0;
        end else if (w_x_wrap) begin
            w_y_nxt = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
        end

        w_hsync_nxt = ~((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
        w_vsync_nxt = ~((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
        w_disp_nxt  = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
    end

    // Flags decode the next-state counters so they land in the same cycle as x/y.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_in_display  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_toggle) begin
                r_x           <= w_x_nxt;
                r_y           <= w_y_nxt;
                r_hsync       <= w_hsync_nxt;
                r_vsync       <= w_vsync_nxt;
                r_in_display  <= w_disp_nxt;
                r_line_start  <= (w_x_nxt == 10'd0);
                r_frame_start <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
            end
        end
    end

    assign vga.pix_tick    = r_toggle;
    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.in_display  = r_in_display;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 16x7 raster instance.
// Per-cycle expectations are queued at each clock edge and compared half a cycle later.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if small_if ();

    vga_timing_gen u_big (
        .clock_50MHz (clk),
        .reset_n     (rst_n),
        .vga         (big_if)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_small (
        .clock_50MHz (clk),
        .reset_n     (rst_n),
        .vga         (small_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: position is derived from the tick count since reset, not stepped.
    function automatic logic [25:0] exp_vec(input int e, input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf, input int vs,
                                            input int vb);
        int   ht;
        int   vt;
        int   k;
        int   lin;
        int   x;
        int   y;
        logic p;
        logic hsn;
        logic vsn;
        logic disp;
        logic ls;
        logic fs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        k  = e / 2;
        p  = (e % 2 == 1);
        if (k == 0) begin
            x = ht - 1; y = vt - 1;
            hsn = 1'b1; vsn = 1'b1; disp = 1'b0; ls = 1'b0; fs = 1'b0;
        end else begin
            lin  = (k - 1) % (ht * vt);
            x    = lin % ht;
            y    = lin / ht;
            hsn  = !((x >= ha + hf) && (x < ha + hf + hs));
            vsn  = !((y >= va + vf) && (y < va + vf + vs));
            disp = (x < ha) && (y < va);
            ls   = (e % 2 == 0) && (x == 0);
            fs   = ls && (y == 0);
        end
        return {p, 10'(x), 10'(y), hsn, vsn, disp, ls, fs};
    endfunction

    function automatic logic [25:0] exp_big(input int e);
        return exp_vec(e, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [25:0] exp_small(input int e);
        return exp_vec(e, 8, 2, 3, 3, 4, 1, 1, 1);
    endfunction

    logic [25:0] big_obs;
    logic [25:0] small_obs;
    assign big_obs   = {big_if.pix_tick, big_if.pixel_x, big_if.pixel_y, big_if.hsync,
                        big_if.vsync, big_if.in_display, big_if.line_start, big_if.frame_start};
    assign small_obs = {small_if.pix_tick, small_if.pixel_x, small_if.pixel_y, small_if.hsync,
                        small_if.vsync, small_if.in_display, small_if.line_start, small_if.frame_start};

    int          e_cnt = 0;
    int          last_fs_small = 0;
    int          last_ls_big = 0;
    logic [25:0] q_big[$];
    logic [25:0] q_small[$];

    always @(negedge rst_n) begin
        e_cnt = 0;
        last_fs_small = 0;
        last_ls_big = 0;
        q_big.delete();
        q_small.delete();
    end

    always @(posedge clk) begin
        if (rst_n) begin
            e_cnt = e_cnt + 1;
            q_big.push_back(exp_big(e_cnt));
            q_small.push_back(exp_small(e_cnt));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("rst_big", 32'(big_obs), 32'(exp_big(0)));
            check_val("rst_small", 32'(small_obs), 32'(exp_small(0)));
        end else if (q_big.size() > 0 && q_small.size() > 0) begin
            check_val("cyc_big", 32'(big_obs), 32'(q_big.pop_front()));
            check_val("cyc_small", 32'(small_obs), 32'(q_small.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && small_if.frame_start) begin
            if (last_fs_small > 0)
                check_val("frame_ticks_small", 32'((e_cnt - last_fs_small) / 2), 32'd112);
            last_fs_small = e_cnt;
        end
        if (rst_n && big_if.line_start) begin
            if (last_ls_big > 0)
                check_val("line_ticks_big", 32'((e_cnt - last_ls_big) / 2), 32'd800);
            last_ls_big = e_cnt;
        end
    end

    task automatic startup_seq();
        #2;
        check_val("start_tick0", 32'(big_if.pix_tick), 32'd0);
        @(negedge clk);
        check_val("start_tick1", 32'(big_if.pix_tick), 32'd1);
        check_val("start_x_hold", 32'(big_if.pixel_x), 32'd799);
        @(negedge clk);
        check_val("start_xy", {12'd0, big_if.pixel_x, big_if.pixel_y}, 32'd0);
        check_val("start_fs", 32'(big_if.frame_start), 32'd1);
        check_val("start_ls", 32'(big_if.line_start), 32'd1);
        check_val("start_disp", 32'(big_if.in_display), 32'd1);
        check_val("start_small_fs", 32'(small_if.frame_start), 32'd1);
        @(negedge clk);
        check_val("start_fs_drop", 32'(big_if.frame_start), 32'd0);
        check_val("start_x_stay", 32'(big_if.pixel_x), 32'd0);
    endtask

    initial begin
        int hs_low;
        int hs_first;
        int disp_fall;
        int guard;

        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_x", 32'(big_if.pixel_x), 32'd799);
        check_val("rst_y", 32'(big_if.pixel_y), 32'd524);
        check_val("rst_syncs", {30'd0, big_if.hsync, big_if.vsync}, 32'd3);
        check_val("rst_flags", {29'd0, big_if.in_display, big_if.line_start, big_if.frame_start}, 32'd0);
        check_val("rst_small_xy", {12'd0, small_if.pixel_x, small_if.pixel_y}, {12'd0, 10'd15, 10'd6});
        #1 rst_n = 1'b1;
        startup_seq();

        // Walk the rest of line 0, one sample per tick.
        hs_low = 0; hs_first = -1; disp_fall = -1;
        for (int i = 1; i < 800; i++) begin
            repeat (2) @(negedge clk);
            if (!big_if.hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(big_if.pixel_x);
            end
            if (!big_if.in_display && disp_fall < 0) disp_fall = int'(big_if.pixel_x);
        end
        check_val("hsync_ticks", 32'(hs_low), 32'd96);
        check_val("hsync_first_x", 32'(hs_first), 32'd656);
        check_val("disp_fall_x", 32'(disp_fall), 32'd640);
        check_val("line0_end", {12'd0, big_if.pixel_x, big_if.pixel_y}, {12'd0, 10'd799, 10'd0});

        guard = 0;
        while (!(big_if.pixel_x == 10'd799 && big_if.pixel_y == 10'd10) && guard < 20000) begin
            repeat (2) @(negedge clk);
            guard++;
        end
        check_val("at_799_10", {12'd0, big_if.pixel_x, big_if.pixel_y}, {12'd0, 10'd799, 10'd10});
        @(negedge clk);
        check_val("wrap_xy", {12'd0, big_if.pixel_x, big_if.pixel_y}, {12'd0, 10'd0, 10'd11});
        check_val("wrap_ls", 32'(big_if.line_start), 32'd1);
        check_val("wrap_fs", 32'(big_if.frame_start), 32'd0);

        // Catch the small raster inside both sync pulses, then reset asynchronously.
        guard = 0;
        while (!(small_if.hsync == 1'b0 && small_if.vsync == 1'b0) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_val("small_both_sync", {30'd0, small_if.hsync, small_if.vsync}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_small_syncs", {30'd0, small_if.hsync, small_if.vsync}, 32'd3);
        check_val("arst_small_xy", {12'd0, small_if.pixel_x, small_if.pixel_y}, {12'd0, 10'd15, 10'd6});
        check_val("arst_big_xy", {12'd0, big_if.pixel_x, big_if.pixel_y}, {12'd0, 10'd799, 10'd524});
        check_val("arst_tick", 32'(big_if.pix_tick), 32'd0);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b1;
        startup_seq();

        repeat (600) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clock_50MHz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-010 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port pix_tick, output, 1 bit: pixel-rate enable, high in every second clock_50MHz cycle.
REQ-012 SHALL have port pixel_x, output, 10 bits: current horizontal position, 0..H_TOTAL-1.
REQ-013 SHALL have port pixel_y, output, 10 bits: current vertical position, 0..V_TOTAL-1.
REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-015 SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-016 SHALL have port in_display, output, 1 bit: high when the current position is visible.
REQ-017 SHALL have port line_start, output, 1 bit: one-clock pulse when pixel_x becomes 0.
REQ-018 SHALL have port frame_start, output, 1 bit: one-clock pulse when pixel_x and pixel_y both become 0.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 SHALL generate pix_tick from a 1-bit toggle register: 0 at reset, inverted every clock; pix_tick = toggle register value.
REQ-021 SHALL advance the counters only in cycles where pix_tick=1; in all other cycles every output except pix_tick SHALL hold.
REQ-022 On a tick, pixel_x SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-023 pixel_y SHALL increment only on a tick where pixel_x wraps; at V_TOTAL-1 it SHALL wrap to 0 in the same tick.
REQ-024 hsync SHALL be 0 exactly when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-025 vsync SHALL be 0 exactly when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-026 in_display SHALL be 1 exactly when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-027 hsync, vsync, in_display, line_start and frame_start SHALL be registered, computed from next-state counter values, so they align with pixel_x/pixel_y in the same cycle (zero relative latency, no combinational path to outputs).
REQ-028 line_start SHALL be 1 for exactly the one clock following the tick in which pixel_x wraps to 0; frame_start likewise when both wrap.
REQ-029 Counter values outside 0..TOTAL-1 SHALL be unreachable; any out-of-range value SHALL wrap to 0 on the next tick.

Reset
REQ-030 While reset_n=0, SHALL hold: toggle=0, pix_tick=0, pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524), hsync=1, vsync=1, in_display=0, line_start=0, frame_start=0.
REQ-031 Reset assertion SHALL take effect immediately (asynchronously), including mid-line or mid-sync pulse, forcing hsync/vsync high.
REQ-032 After reset_n rises, the first pix_tick SHALL occur in the second clock; that tick SHALL move the counters to (0,0) and raise in_display, line_start, frame_start in the same cycle.

Verification
REQ-033 Reset held 10 clocks -> outputs exactly as REQ-030; release -> clock 1 pix_tick=0, clock 2 pix_tick=1, then (0,0), frame_start=1 for 1 clock, in_display=1.
REQ-034 Run one line -> hsync low for exactly 96 ticks starting at pixel_x=656; in_display falls when pixel_x reaches 640.
REQ-035 At pixel_x=799, pixel_y=10, next tick -> pixel_x=0, pixel_y=11, line_start=1, frame_start=0.
REQ-036 Run full frame -> vsync low for exactly 2 lines (y=490,491, 1600 ticks); at (799,524) next tick -> (0,0) with frame_start=1; frame period 420000 ticks / 840000 clocks.
REQ-037 Assert reset_n=0 at pixel_x=700, pixel_y=491 (both syncs low) -> hsync=vsync=1 and counters (799,524) without waiting for a clock edge; release -> REQ-032 sequence repeats.
REQ-038 Override parameters (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1) -> H_TOTAL=16, V_TOTAL=7, hsync low for x=10..12, vsync low for y=5, frame period 112 ticks.
